// File: rtl/lane_pkg.sv
// Shared types and default patterns for the scrolling traffic lanes.
package lane_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    DEAD = 1'b1
  } lane_state_t;

  localparam int unsigned LANE_WIDTH_DEF    = 16;
  localparam int unsigned LANE_PERIOD_W_DEF = 9;

  localparam logic [15:0] LANE_INIT_16 = 16'h8C63;
  localparam logic [15:0] LANE_GG_16   = 16'h9989;

endpackage : lane_pkg

// File: rtl/lane_tick.sv
// Programmable tick divider: tick_c fires on enabled cycles where count >= period.
module lane_tick #(
  parameter int unsigned PERIOD_W = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick_c
);

  logic [PERIOD_W-1:0] count;

  // >= rather than == so a period lowered below count ticks at once.
  assign tick_c = enable & ~clear & (count >= period);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick_c ? '0 : count + PERIOD_W'(1);
    end
  end

endmodule : lane_tick

// File: rtl/lane_scroller.sv
// Frogger traffic lane: rotates a WIDTH-bit pattern per tick, freezes to GG_PATTERN on a hit.
// Define LANE_COLLIDE_EN to kill the lane on an internal frog/car collision.
module lane_scroller
  import lane_pkg::*;
#(
  parameter int unsigned       WIDTH        = LANE_WIDTH_DEF,
  parameter int unsigned       PERIOD_W     = LANE_PERIOD_W_DEF,
  parameter logic [WIDTH-1:0]  INIT_PATTERN = WIDTH'(LANE_INIT_16),
  parameter logic [WIDTH-1:0]  GG_PATTERN   = WIDTH'(LANE_GG_16)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [PERIOD_W-1:0]      period,
  input  logic                     dir,
  input  logic                     hit,
  input  logic                     restart,
  input  logic                     frog_lane,
  input  logic [$clog2(WIDTH)-1:0] frog_col,
  output logic [WIDTH-1:0]         pixels,
  output logic                     step,
  output logic                     dead,
  output logic                     collide
);

  lane_state_t state;
  logic        tick_c;
  logic        kill_c;
  logic        car_c;
  logic        div_en_c;

`ifdef LANE_COLLIDE_EN
  assign car_c  = frog_lane & (32'(frog_col) < WIDTH) & pixels[frog_col];
  assign kill_c = hit | collide;
`else
  logic unused_frog;
  assign unused_frog = ^{frog_lane, frog_col};
  assign car_c  = 1'b0;
  assign kill_c = hit;
`endif

  // Divider only advances while alive and not being killed this cycle.
  assign div_en_c = enable & (state == RUN) & ~kill_c;

  lane_tick #(
    .PERIOD_W (PERIOD_W)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (div_en_c),
    .clear  (restart),
    .period (period),
    .tick_c (tick_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      pixels  <= INIT_PATTERN;
      step    <= 1'b0;
      dead    <= 1'b0;
      collide <= 1'b0;
    end else begin
      step <= 1'b0;
      if (restart) begin
        state   <= RUN;
        pixels  <= INIT_PATTERN;
        dead    <= 1'b0;
        collide <= 1'b0;
      end else if (state == RUN) begin
        collide <= car_c;
        if (kill_c) begin
          state  <= DEAD;
          pixels <= GG_PATTERN;
          dead   <= 1'b1;
        end else if (tick_c) begin
          pixels <= dir ? {pixels[0], pixels[WIDTH-1:1]}
                        : {pixels[WIDTH-2:0], pixels[WIDTH-1]};
          step   <= 1'b1;
        end
      end else begin
        collide <= 1'b0;
      end
    end
  end

endmodule : lane_scroller

// File: tb/tb_lane_scroller.sv
// Directed self-checking bench for lane_scroller with hand-computed patterns.
module tb_lane_scroller;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned PERIOD_W = 9;

  logic                     clk;
  logic                     reset;
  logic                     enable;
  logic [PERIOD_W-1:0]      period;
  logic                     dir;
  logic                     hit;
  logic                     restart;
  logic                     frog_lane;
  logic [$clog2(WIDTH)-1:0] frog_col;
  logic [WIDTH-1:0]         pixels;
  logic                     step;
  logic                     dead;
  logic                     collide;

  int n_checks = 0;
  int n_fail   = 0;

  lane_scroller #(
    .WIDTH    (WIDTH),
    .PERIOD_W (PERIOD_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .period    (period),
    .dir       (dir),
    .hit       (hit),
    .restart   (restart),
    .frog_lane (frog_lane),
    .frog_col  (frog_col),
    .pixels    (pixels),
    .step      (step),
    .dead      (dead),
    .collide   (collide)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle past it before sampling.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; period = '0; dir = 1'b0;
    hit = 1'b0; restart = 1'b0; frog_lane = 1'b0; frog_col = '0;

    #12;
    check("rst_pixels", 32'(pixels), 32'h8C63);
    check("rst_step", 32'(step), 32'd0);
    check("rst_dead", 32'(dead), 32'd0);
    check("rst_collide", 32'(collide), 32'd0);

    @(negedge clk);
    reset = 1'b1;
    cyc(); check("rotl1", 32'(pixels), 32'h18C7); check("rotl1_step", 32'(step), 32'd1);
    cyc(); check("rotl2", 32'(pixels), 32'h318E);
    cyc(); check("rotl3", 32'(pixels), 32'h631C);

    // period=3, rotate right: one rotation every 4 cycles
    period = 9'd3; dir = 1'b1;
    cyc(); check("p3_c1_step", 32'(step), 32'd0); check("p3_c1_pix", 32'(pixels), 32'h631C);
    cyc(); check("p3_c2_step", 32'(step), 32'd0);
    cyc(); check("p3_c3_step", 32'(step), 32'd0); check("p3_c3_pix", 32'(pixels), 32'h631C);
    cyc(); check("p3_c4_pix", 32'(pixels), 32'h318E); check("p3_c4_step", 32'(step), 32'd1);
    cyc(4); check("p3_c8_pix", 32'(pixels), 32'h18C7); check("p3_c8_step", 32'(step), 32'd1);

    // Pause with count=2; count must hold across the pause
    cyc(2);
    enable = 1'b0;
    cyc(10); check("pause_pix", 32'(pixels), 32'h18C7); check("pause_step", 32'(step), 32'd0);
    enable = 1'b1;
    cyc(); check("resume_c1_step", 32'(step), 32'd0); check("resume_c1_pix", 32'(pixels), 32'h18C7);
    cyc(); check("resume_c2_pix", 32'(pixels), 32'h8C63); check("resume_c2_step", 32'(step), 32'd1);

    // Full wrap in both directions
    period = '0; dir = 1'b0;
    cyc(16); check("wrap_left", 32'(pixels), 32'h8C63);
    dir = 1'b1;
    cyc(16); check("wrap_right", 32'(pixels), 32'h8C63);

    // Lower period below current count
    period = 9'd9;
    cyc(5); check("p9_hold", 32'(pixels), 32'h8C63); check("p9_step", 32'(step), 32'd0);
    period = 9'd1;
    cyc(); check("plow_pix", 32'(pixels), 32'hC631); check("plow_step", 32'(step), 32'd1);

    // Hit together with a tick: dead, GG pattern, no rotation
    period = '0; hit = 1'b1;
    cyc(); check("hit_pix", 32'(pixels), 32'h9989); check("hit_dead", 32'(dead), 32'd1);
    check("hit_step", 32'(step), 32'd0);
    hit = 1'b0;
    cyc(3); check("dead_hold_pix", 32'(pixels), 32'h9989); check("dead_hold", 32'(dead), 32'd1);
    check("dead_step", 32'(step), 32'd0);
    hit = 1'b1;
    cyc(2); check("dead_rehit_pix", 32'(pixels), 32'h9989); check("dead_collide", 32'(collide), 32'd0);

    // Restart beats hit
    restart = 1'b1;
    cyc(); check("rs_pix", 32'(pixels), 32'h8C63); check("rs_dead", 32'(dead), 32'd0);
    check("rs_step", 32'(step), 32'd0);
    restart = 1'b0; hit = 1'b0;
    cyc(); check("rs_next_pix", 32'(pixels), 32'hC631); check("rs_next_step", 32'(step), 32'd1);

    // Collision: freeze lane at INIT, frog on column 2 (empty) then column 0 (car)
    restart = 1'b1; enable = 1'b0;
    cyc();
    restart = 1'b0; frog_lane = 1'b1; frog_col = 4'd2;
    cyc(2); check("col2_collide", 32'(collide), 32'd0); check("col2_dead", 32'(dead), 32'd0);
    frog_col = 4'd0;
`ifdef LANE_COLLIDE_EN
    cyc(); check("col0_collide", 32'(collide), 32'd1); check("col0_dead1", 32'(dead), 32'd0);
    cyc(); check("col0_dead2", 32'(dead), 32'd1); check("col0_pix", 32'(pixels), 32'h9989);
    cyc(); check("col0_dead_collide", 32'(collide), 32'd0);
`else
    cyc(); check("nocol_collide", 32'(collide), 32'd0);
    cyc(); check("nocol_dead", 32'(dead), 32'd0); check("nocol_pix", 32'(pixels), 32'h8C63);
`endif
    frog_lane = 1'b0; restart = 1'b1;
    cyc(); check("final_rs_pix", 32'(pixels), 32'h8C63); check("final_rs_dead", 32'(dead), 32'd0);
    restart = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_lane_scroller

// File: doc/lane_scroller.md
# lane_scroller

- Parametrised Frogger traffic lane for the LED-matrix playfield.
- Holds a WIDTH-bit lane pattern and rotates it one column per programmable tick, in a run-time selectable direction.
- Supports pause and restart, and freezes to a game-over pattern on a hit.
- Optionally detects frog/car collision internally.
- One instance per road row; the display driver consumes `pixels` directly.

## Interface
Parameters:
- WIDTH, 16, lane width in pixels (≥2)
- PERIOD_W, 9, width of tick divider and `period` input
- INIT_PATTERN, 16'h8C63, pattern loaded on reset/restart (WIDTH bits)
- GG_PATTERN, 16'h9989, pattern shown while dead (WIDTH bits)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  1 = lane scrolls; 0 = paused (divider holds)
- period  in  PERIOD_W  tick every period+1 cycles
- dir  in  1  0 = rotate left (toward MSB), 1 = rotate right
- hit  in  1  external kill request
- restart  in  1  reload INIT_PATTERN, return to RUN
- frog_lane  in  1  frog currently occupies this row
- frog_col  in  $clog2(WIDTH)  frog column index
- pixels  out  WIDTH  current lane pattern
- step  out  1  one-cycle pulse, high in the cycle after a rotation
- dead  out  1  high in DEAD state
- collide  out  1  registered frog-on-car flag

## Operation
- States: RUN, DEAD.
- Reset (reset=0, async): state RUN, pixels=INIT_PATTERN, divider count=0, step=0, dead=0, collide=0.
- Divider:
  - In RUN with enable=1, count increments each cycle.
  - When count ≥ period: tick, count←0.
  - enable=0 holds count. period=0 gives a tick every enabled cycle.
  - Lowering period below count causes a tick on the next enabled cycle.
- On tick in RUN:
  - dir=0: pixels←{pixels[WIDTH-2:0], pixels[WIDTH-1]}.
  - dir=1: pixels←{pixels[0], pixels[WIDTH-1:1]}.
  - step=1 for one cycle.
- RUN→DEAD on hit=1, or on internal collision (when configured). The transition loads pixels←GG_PATTERN and sets dead=1. No rotation occurs in that cycle.
- DEAD is sticky: pixels, dead and count hold; hit, enable and ticks are ignored.
- restart=1, either state: state RUN, pixels←INIT_PATTERN, count←0, dead←0, step←0.
- Priority, highest first: reset, restart, hit/collision, tick.
- collide (registered): collide←frog_lane & pixels[frog_col], evaluated in RUN only; 0 in DEAD.
- frog_col ≥ WIDTH reads as no car.

## Timing
- All outputs registered; no combinational input→output paths.
- Rotation is visible on pixels in the cycle after the tick condition; step is high in that same cycle.
- hit→dead/GG_PATTERN latency: 1 cycle.
- Collision path (frog_lane/frog_col → collide): 1 cycle.
- Collision→DEAD: 2 cycles (registered collide, then transition).
- Restart latency: 1 cycle. Rotation resumes period+1 enabled cycles later.
- Full pattern wrap: WIDTH ticks return pixels to its starting value.

## Configuration
- Macro: LANE_COLLIDE_EN.
- Defined: a registered collide=1 while in RUN forces DEAD exactly as hit does.
- Undefined: collide is tied 0, frog_lane and frog_col are unused, and only hit or restart change state.

## Structure
- Package lane_pkg:
  - state enum lane_state_t {RUN, DEAD}
  - default pattern constants LANE_INIT_16 = 16'h8C63, LANE_GG_16 = 16'h9989
- Sub-module lane_tick: PERIOD_W-bit divider with enable, clear and period inputs and a tick output; reused by other moving-object lanes.

## Test plan
- Reset with period=0, enable=1, dir=0 → pixels=8C63 during reset. Successive cycles show 18C7, 318E, 631C.
- period=3, dir=1 → one right rotation every 4 cycles with a matching step pulse. Toggling enable low for 10 cycles freezes pixels and count.
- Simultaneous hit and tick → pixels=9989, dead=1 next cycle, no rotation. Further ticks and hits leave the outputs unchanged.
- DEAD, then restart=1 together with hit=1 → RUN, pixels=8C63, dead=0; restart wins.
- LANE_COLLIDE_EN defined, pixels=8C63, frog_lane=1, frog_col=0 → collide=1 after 1 cycle, dead=1 after 2 cycles. With frog_col=2 → collide stays 0.
- 16 ticks in either direction → pixels returns to 8C63. period lowered from 9 to 1 while count=5 → tick on the next enabled cycle.
